// File: rtl/simple_8bit_adder_pkg.sv
// Shared constants for the registered carry-lookahead adder.
package simple_8bit_adder_pkg;
    localparam int ADDER_WIDTH = 8;
    localparam int CLA_GROUP   = 4;
endpackage : simple_8bit_adder_pkg

// File: rtl/simple_8bit_adder_cla4_group.sv
// 4-bit carry-lookahead slice. Internal carries are fully expanded.
// The carry-out is formed from the group generate/propagate terms.
module cla4_group (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [3:0] w_c;
    logic       w_group_g;
    logic       w_group_p;

    assign w_g = a & b;
    assign w_p = a ^ b;

    assign w_c[0] = cin;
    assign w_c[1] = w_g[0] | (w_p[0] & cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & cin);

    assign w_group_g = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                     | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
    assign w_group_p = &w_p;

    assign sum  = w_p ^ w_c;
    assign cout = w_group_g | (w_group_p & cin);
endmodule : cla4_group

// File: rtl/simple_8bit_adder.sv
// Registered unsigned adder: {cout,sum} <= a + b + cin, one-cycle latency.
// Carry ripples between 4-bit lookahead groups; synchronous active-low reset.
module simple_8bit_adder
    import simple_8bit_adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int NUM_GROUPS = WIDTH / CLA_GROUP;

    if ((WIDTH % CLA_GROUP) != 0 || WIDTH < CLA_GROUP) begin : g_width_check
        $error("simple_8bit_adder: WIDTH must be a positive multiple of 4");
    end

    logic [NUM_GROUPS:0] w_carry;
    logic [WIDTH-1:0]    w_sum;
    logic [WIDTH-1:0]    r_sum;
    logic                r_cout;

    assign w_carry[0] = cin;

    for (genvar gi = 0; gi < NUM_GROUPS; gi++) begin : g_group
        cla4_group u_cla4_group (
            .a    (a[gi*CLA_GROUP +: CLA_GROUP]),
            .b    (b[gi*CLA_GROUP +: CLA_GROUP]),
            .cin  (w_carry[gi]),
            .sum  (w_sum[gi*CLA_GROUP +: CLA_GROUP]),
            .cout (w_carry[gi+1])
        );
    end

    // Output register: reset wins over the addition at the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sum  <= {WIDTH{1'b0}};
            r_cout <= 1'b0;
        end else begin
            r_sum  <= w_sum;
            r_cout <= w_carry[NUM_GROUPS];
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
endmodule : simple_8bit_adder

// File: tb/tb_simple_8bit_adder.sv
// Self-checking bench: directed corners, reset behaviour and random vectors
// compared against a plain-arithmetic reference with one-cycle latency.
module tb_simple_8bit_adder;
    logic       clk;
    logic       rst_n;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;

    int n_checks = 0;
    int n_errors = 0;

    simple_8bit_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [8:0] obs, input logic [8:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("ERROR FAIL %s: got cout/sum=%b/%h, expected %b/%h",
                     tag, obs[8], obs[7:0], exp_v[8], exp_v[7:0]);
        end
    endtask

    function automatic logic [8:0] ref_add(input logic [7:0] x, input logic [7:0] y, input logic c);
        int total;
        total = int'(x) + int'(y) + int'(c);
        return total[8:0];
    endfunction

    // Drive operands, take one edge, then compare just after it.
    task automatic add_and_check(input string tag, input logic [7:0] x, input logic [7:0] y,
                                 input logic c, input logic [8:0] exp_v);
        a   = x;
        b   = y;
        cin = c;
        @(posedge clk);
        #1;
        check_val(tag, {cout, sum}, exp_v);
        if (ref_add(x, y, c) !== exp_v) begin
            n_errors++;
            $display("ERROR FAIL %s_model: reference %h disagrees with table %h",
                     tag, ref_add(x, y, c), exp_v);
        end
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;

        rst_n = 1'b0;
        a     = 8'hFF;
        b     = 8'hFF;
        cin   = 1'b1;
        @(posedge clk);
        #1;
        check_val("reset_init", {cout, sum}, 9'h000);

        // First edge out of reset loads the current inputs directly.
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_val("first_after_reset", {cout, sum}, 9'h1FF);

        add_and_check("basic_01_01_0", 8'h01, 8'h01, 1'b0, 9'h002);
        add_and_check("basic_0f_0f_0", 8'h0F, 8'h0F, 1'b0, 9'h01E);
        add_and_check("basic_aa_55_0", 8'hAA, 8'h55, 1'b0, 9'h0FF);
        add_and_check("basic_ff_00_0", 8'hFF, 8'h00, 1'b0, 9'h0FF);
        add_and_check("corner_ff_ff_0", 8'hFF, 8'hFF, 1'b0, 9'h1FE);
        add_and_check("corner_ff_00_1", 8'hFF, 8'h00, 1'b1, 9'h100);
        add_and_check("corner_00_00_0", 8'h00, 8'h00, 1'b0, 9'h000);
        add_and_check("wrap_ff_01_0", 8'hFF, 8'h01, 1'b0, 9'h100);
        add_and_check("max_ff_ff_1", 8'hFF, 8'hFF, 1'b1, 9'h1FF);
        add_and_check("stable_ff_ff_1", 8'hFF, 8'hFF, 1'b1, 9'h1FF);
        add_and_check("chain_00_00_1", 8'h00, 8'h00, 1'b1, 9'h001);
        add_and_check("chain_0f_00_1", 8'h0F, 8'h00, 1'b1, 9'h010);
        add_and_check("chain_7f_01_0", 8'h7F, 8'h01, 1'b0, 9'h080);
        $display("PASS directed vectors done (%0d errors so far)", n_errors);

        // Mid-stream reset: no asynchronous effect, then clears at the edge.
        add_and_check("pre_reset", 8'hFF, 8'hFF, 1'b1, 9'h1FF);
        rst_n = 1'b0;
        #2;
        check_val("reset_not_async", {cout, sum}, 9'h1FF);
        @(posedge clk);
        #1;
        check_val("reset_midstream", {cout, sum}, 9'h000);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_val("reset_release", {cout, sum}, 9'h1FF);

        for (int i = 0; i < 1200; i++) begin
            ra = 8'($urandom_range(255, 0));
            rb = 8'($urandom_range(255, 0));
            rc = 1'($urandom_range(1, 0));
            a   = ra;
            b   = rb;
            cin = rc;
            @(posedge clk);
            #1;
            check_val("random", {cout, sum}, ref_add(ra, rb, rc));
        end
        $display("PASS random vectors done");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule : tb_simple_8bit_adder

// File: doc/simple_8bit_adder.md
SIMPLE_8BIT_ADDER -- requirements
Module: simple_8bit_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand and sum width; only 8 is required to be verified.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 a  input  WIDTH  first operand, unsigned.
REQ-005 b  input  WIDTH  second operand, unsigned.
REQ-006 cin  input  1  carry-in, weight 1.
REQ-007 sum  output  WIDTH  registered low WIDTH bits of a+b+cin.
REQ-008 cout  output  1  registered carry-out (bit WIDTH of a+b+cin).

Function
REQ-009 Each rising clk edge with rst_n=1 SHALL load {cout,sum} with the (WIDTH+1)-bit unsigned result of a+b+cin sampled at that edge.
REQ-010 Latency SHALL be exactly one cycle: result of inputs sampled at edge N visible after edge N, held until edge N+1.
REQ-011 No handshake or enable; a new result is computed every cycle, and stable inputs SHALL give a stable output.
REQ-012 Overflow SHALL wrap modulo 2^WIDTH in sum, with the lost bit in cout: FF+01+0 -> sum 00, cout 1.
REQ-013 Maximum case FF+FF+1 SHALL give sum FF, cout 1; minimum 00+00+0 SHALL give sum 00, cout 0.
REQ-014 cin alone SHALL propagate through a full carry chain: FF+00+1 -> sum 00, cout 1.
REQ-015 Carry logic SHALL be a ripple of 4-bit carry-lookahead groups: group generate/propagate from per-bit g=a&b and p=a^b, and group carry-out = G | P&cin_group.
REQ-016 The combinational path SHALL be purely combinational, with no latches. sum bit i = p_i ^ c_i.
REQ-017 sum and cout SHALL never be X after the first edge with rst_n=0 when inputs are known.

Reset
REQ-018 On a rising clk edge with rst_n=0, sum SHALL become 0 and cout SHALL become 0, regardless of a, b and cin.
REQ-019 Reset SHALL have no asynchronous effect: outputs SHALL keep their value between rst_n falling and the next rising clk edge.
REQ-020 Reset asserted mid-stream SHALL override the addition at that edge.
REQ-021 The first edge with rst_n=1 SHALL load a+b+cin from the current inputs, with no extra warm-up cycle.

Structure
REQ-022 A shared package SHALL hold ADDER_WIDTH=8 and CLA_GROUP=4 constants only; no typedefs are needed.
REQ-023 One sub-module, cla4_group (4-bit lookahead slice: a, b, cin -> sum, cout), SHALL be instantiated WIDTH/4 times in a chain.
REQ-024 WIDTH SHALL be a multiple of 4; other values SHALL be rejected at elaboration.
REQ-025 The top level SHALL contain only the group chain and the output register.

Verification
REQ-026 Bench SHALL compare outputs one cycle after applying inputs, against a reference of a+b+cin, and log PASS/ERROR lines.
REQ-027 Basic: 01+01+0 -> 02/0; 0F+0F+0 -> 1E/0; AA+55+0 -> FF/0; FF+00+0 -> FF/0.
REQ-028 Corner: FF+FF+0 -> FE/1; FF+00+1 -> 00/1; 00+00+0 -> 00/0.
REQ-029 Carry chain: 00+00+1 -> 01/0; 0F+00+1 -> 10/0; 7F+01+0 -> 80/0.
REQ-030 Reset: drive FF+FF+1, then rst_n=0 for one edge -> 00/0; release -> FF/1 on the next edge.
REQ-031 Random: at least 1000 random a, b, cin vectors, each matching the reference with one-cycle latency.
